// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// With MEMARB_LOCK_EN defined, the per-port lock inputs are included.
interface mem_arbiter_if #(
  parameter int unsigned BUS_SIZE  = 32,
  parameter int unsigned ADDR_SIZE = 8
);
  logic                 reqA;
  logic                 weA;
  logic [ADDR_SIZE-1:0] addrA;
  logic [BUS_SIZE-1:0]  wdataA;
  logic                 ackA;
  logic [BUS_SIZE-1:0]  rdataA;

  logic                 reqB;
  logic                 weB;
  logic [ADDR_SIZE-1:0] addrB;
  logic [BUS_SIZE-1:0]  wdataB;
  logic                 ackB;
  logic [BUS_SIZE-1:0]  rdataB;

`ifdef MEMARB_LOCK_EN
  logic                 lockA;
  logic                 lockB;
`endif

  logic                 busy;
  logic                 memEnWrite;
  logic [ADDR_SIZE-1:0] memDir;
  logic [BUS_SIZE-1:0]  memWriteData;
  logic [BUS_SIZE-1:0]  memOut;

  // Arbiter side
  modport slave (
    input  reqA, weA, addrA, wdataA,
    input  reqB, weB, addrB, wdataB,
`ifdef MEMARB_LOCK_EN
    input  lockA, lockB,
`endif
    output ackA, rdataA, ackB, rdataB,
    output busy, memEnWrite, memDir, memWriteData,
    input  memOut
  );

  // Requester / memory side
  modport master (
    output reqA, weA, addrA, wdataA,
    output reqB, weB, addrB, wdataB,
`ifdef MEMARB_LOCK_EN
    output lockA, lockB,
`endif
    input  ackA, rdataA, ackB, rdataB,
    input  busy, memEnWrite, memDir, memWriteData,
    output memOut
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the single-port 256-word data memory.
// Optional MEMARB_LOCK_EN adds lockA/lockB for back-to-back burst accesses by one owner.
module mem_arbiter #(
  parameter int unsigned BUS_SIZE  = 32,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic          clk,
  input  logic          nReset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t               r_state;
  logic                 r_owner;
  logic                 r_rr_next;
  logic                 r_we;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [BUS_SIZE-1:0]  r_wdata;
  logic                 r_en_write;
  logic                 r_busy;
  logic                 r_ack_a;
  logic                 r_ack_b;
  logic [BUS_SIZE-1:0]  r_rdata_a;
  logic [BUS_SIZE-1:0]  r_rdata_b;

  logic                 w_req_any;
  logic                 w_grant_b;
  logic                 w_src;
  logic                 w_sel_we;
  logic [ADDR_SIZE-1:0] w_sel_addr;
  logic [BUS_SIZE-1:0]  w_sel_wdata;
  logic                 w_lock_cont;

  // B wins only when A is idle or it is B's turn on a tie
  always_comb begin
    w_req_any   = bus.reqA | bus.reqB;
    w_grant_b   = bus.reqB & (~bus.reqA | (r_rr_next == PORT_B));
    w_src       = (r_state == ST_IDLE) ? w_grant_b : r_owner;
    w_sel_we    = (w_src == PORT_B) ? bus.weB    : bus.weA;
    w_sel_addr  = (w_src == PORT_B) ? bus.addrB  : bus.addrA;
    w_sel_wdata = (w_src == PORT_B) ? bus.wdataB : bus.wdataA;
  end

`ifdef MEMARB_LOCK_EN
  // Owner keeps the memory when it holds lock and already presents its next request
  always_comb begin
    w_lock_cont = (r_owner == PORT_B) ? (bus.lockB & bus.reqB)
                                      : (bus.lockA & bus.reqA);
  end
`else
  always_comb begin
    w_lock_cont = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= ST_IDLE;
      r_owner    <= PORT_A;
      r_rr_next  <= PORT_A;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_en_write <= 1'b0;
      r_busy     <= 1'b0;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_owner    <= w_grant_b;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_en_write <= w_sel_we;
            r_busy     <= 1'b1;
            r_state    <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          r_en_write <= 1'b0;
          r_rr_next  <= ~r_owner;
          r_state    <= ST_DONE;
          if (r_owner == PORT_B) begin
            r_ack_b <= 1'b1;
            if (!r_we) r_rdata_b <= bus.memOut;
          end else begin
            r_ack_a <= 1'b1;
            if (!r_we) r_rdata_a <= bus.memOut;
          end
        end

        ST_DONE: begin
          r_ack_a <= 1'b0;
          r_ack_b <= 1'b0;
          if (w_lock_cont) begin
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_en_write <= w_sel_we;
            r_state    <= ST_ACCESS;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_en_write <= 1'b0;
          r_busy     <= 1'b0;
          r_ack_a    <= 1'b0;
          r_ack_b    <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ackA         = r_ack_a;
  assign bus.ackB         = r_ack_b;
  assign bus.rdataA       = r_rdata_a;
  assign bus.rdataB       = r_rdata_b;
  assign bus.busy         = r_busy;
  assign bus.memEnWrite   = r_en_write;
  assign bus.memDir       = r_addr;
  assign bus.memWriteData = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a behavioural 256-word memory.
// Define MEMARB_LOCK_EN to also exercise the lock/burst path.
module tb_mem_arbiter;
  localparam int unsigned BUS_SIZE  = 32;
  localparam int unsigned ADDR_SIZE = 8;

  logic clk    = 1'b0;
  logic nReset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.BUS_SIZE(BUS_SIZE), .ADDR_SIZE(ADDR_SIZE)) bus ();

  mem_arbiter #(.BUS_SIZE(BUS_SIZE), .ADDR_SIZE(ADDR_SIZE)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  // Memory instance stand-in: synchronous write, combinational read
  logic [31:0] mem [256];
  always @(posedge clk) if (bus.memEnWrite) mem[bus.memDir] <= bus.memWriteData;
  assign bus.memOut = mem[bus.memDir];

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_mem [256];
  logic [31:0] mdl_rd_a, mdl_rd_b;
  int          total = 0;
  int          bad   = 0;
  int          en_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack pops one expectation and checks port and read data
  always @(negedge clk) begin
    if (nReset) begin
      if (bus.memEnWrite) en_cnt++;
      if (bus.ackA || bus.ackB) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'({bus.ackA, bus.ackB}), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", 32'({bus.ackA, bus.ackB}), e.port ? 32'd1 : 32'd2);
          chk("rdata", e.port ? bus.rdataB : bus.rdataA, e.data);
        end
      end
    end
  end

  task automatic push(input logic port, input logic we, input logic [7:0] addr, input logic [31:0] wd);
    exp_t e;
    e.port = port;
    if (we) begin
      mdl_mem[addr] = wd;
      e.data = port ? mdl_rd_b : mdl_rd_a;
    end else begin
      e.data = mdl_mem[addr];
      if (port) mdl_rd_b = e.data; else mdl_rd_a = e.data;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic [7:0] addr, input logic [31:0] wd);
    if (port) begin
      bus.reqB = req; bus.weB = we; bus.addrB = addr; bus.wdataB = wd;
    end else begin
      bus.reqA = req; bus.weA = we; bus.addrA = addr; bus.wdataA = wd;
    end
  endtask

  task automatic wait_ack(input logic port, input int max, output int cyc);
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < max) begin
      @(negedge clk);
      cyc++;
      seen = port ? bus.ackB : bus.ackA;
    end
    chk(port ? "ackB_seen" : "ackA_seen", 32'(seen), 32'd1);
  endtask

  // One isolated access from IDLE; returns at a negedge with the DUT idle again
  task automatic do_op(input logic port, input logic we, input logic [7:0] addr, input logic [31:0] wd);
    int cyc;
    push(port, we, addr, wd);
    drive(port, 1'b1, we, addr, wd);
    wait_ack(port, 10, cyc);
    chk("latency", 32'(cyc), 32'd2);
    drive(port, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    sb.delete();
    mdl_rd_a = 32'h0;
    mdl_rd_b = 32'h0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc, e0, a_cnt, b_cnt, n;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h0;
      mdl_mem[i] = 32'h0;
    end
    mdl_rd_a = 32'h0;
    mdl_rd_b = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
`ifdef MEMARB_LOCK_EN
    bus.lockA = 1'b0;
    bus.lockB = 1'b0;
`endif

    // Power-on reset values, before any clock edge
    #1 nReset = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_en", 32'(bus.memEnWrite), 32'd0);
    chk("rst_dir", 32'(bus.memDir), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    // A write then read back
    e0 = en_cnt;
    do_op(1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
    chk("one_wr_en_cycle", 32'(en_cnt - e0), 32'd1);
    do_op(1'b0, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    chk("rdataA_held", bus.rdataA, 32'hDEAD_BEEF);

    // Address 0 on port B
    do_op(1'b1, 1'b1, 8'h00, 32'h0BAD_F00D);
    do_op(1'b1, 1'b0, 8'h00, 32'h0);

    // reqB withdrawn during ACCESS: write still lands, ack still pulses once
    push(1'b1, 1'b1, 8'h05, 32'hA5A5_0005);
    drive(1'b1, 1'b1, 1'b1, 8'h05, 32'hA5A5_0005);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    wait_ack(1'b1, 10, cyc);
    chk("viol_latency", 32'(cyc), 32'd1);
    @(negedge clk);
    chk("viol_idle", 32'(bus.busy), 32'd0);
    do_op(1'b1, 1'b0, 8'h05, 32'h0);

    // Reset mid-ACCESS: outputs clear without a clock edge
    drive(1'b0, 1'b1, 1'b1, 8'h77, 32'h1234_5678);
    @(negedge clk);
    chk("pre_rst_en", 32'(bus.memEnWrite), 32'd1);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 nReset = 1'b0;
    #1;
    chk("rst_en_async", 32'(bus.memEnWrite), 32'd0);
    chk("rst_acks", 32'({bus.ackA, bus.ackB}), 32'd0);
    chk("rst_busy2", 32'(bus.busy), 32'd0);
    chk("rst_rdataA", bus.rdataA, 32'h0);
    chk("rst_rdataB", bus.rdataB, 32'h0);
    chk("rst_wdata", bus.memWriteData, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    mdl_rd_a = 32'h0;
    mdl_rd_b = 32'h0;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    // Simultaneous writes after reset: A first, then B
    e0 = en_cnt;
    push(1'b0, 1'b1, 8'h30, 32'h1111_AAAA);
    push(1'b1, 1'b1, 8'h31, 32'h2222_BBBB);
    drive(1'b0, 1'b1, 1'b1, 8'h30, 32'h1111_AAAA);
    drive(1'b1, 1'b1, 1'b1, 8'h31, 32'h2222_BBBB);
    wait_ack(1'b0, 10, cyc);
    chk("sim_A_latency", 32'(cyc), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    wait_ack(1'b1, 10, cyc);
    chk("sim_B_latency", 32'(cyc), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("sim_en_cycles", 32'(en_cnt - e0), 32'd2);

    // Both held for 12 reads: strict alternation starting with A
    do_reset();
    for (int i = 0; i < 12; i++) push(1'(i % 2), 1'b0, (i % 2 == 0) ? 8'h30 : 8'h31, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h30, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h31, 32'h0);
    a_cnt = 0;
    b_cnt = 0;
    n     = 0;
    while ((a_cnt + b_cnt) < 12 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.ackA) a_cnt++;
      if (bus.ackB) b_cnt++;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) @(negedge clk);
    chk("rr_a_count", 32'(a_cnt), 32'd6);
    chk("rr_b_count", 32'(b_cnt), 32'd6);
    chk("rr_cycles", 32'(n), 32'd35);

`ifdef MEMARB_LOCK_EN
    // Locked burst of four A reads while B waits
    for (int i = 1; i <= 4; i++) do_op(1'b0, 1'b1, 8'(i), 32'hC0DE_0000 + 32'(i));
    do_reset();
    push(1'b0, 1'b0, 8'h01, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h01, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h31, 32'h0);
    bus.lockA = 1'b1;
    wait_ack(1'b0, 10, cyc);
    chk("lock_first", 32'(cyc), 32'd2);
    for (int i = 2; i <= 4; i++) begin
      push(1'b0, 1'b0, 8'(i), 32'h0);
      bus.addrA = 8'(i);
      wait_ack(1'b0, 10, cyc);
      chk("lock_spacing", 32'(cyc), 32'd2);
    end
    push(1'b1, 1'b0, 8'h31, 32'h0);
    bus.lockA = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    wait_ack(1'b1, 10, cyc);
    chk("lock_then_B", 32'(cyc), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) @(negedge clk);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
